// File: rtl/sdh_rx_frame_aligner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdh_rx_pkg
// Brief    : Shared constants and state type for the SDH receive aligner.
// Revision : 1.0 - initial release
// ============================================================================
package sdh_rx_pkg;

   localparam logic [7:0] c_a1_byte     = 8'hF6;
   localparam logic [7:0] c_a2_byte     = 8'h28;
   localparam int         c_frame_bytes = 2430;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PRESYNC = 2'd1,
      SYNC    = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sdh_rx_frame_aligner_if.sv
`default_nettype none
// ============================================================================
// Module   : sdh_rx_frame_aligner_if
// Brief    : GTX word input and aligned byte output bundle of the aligner.
// Revision : 1.0 - initial release
// ============================================================================
interface sdh_rx_frame_aligner_if;

   logic [31:0] gtx_rx_data;
   logic        gtx_rx_vld;
   logic [7:0]  rx_byte;
   logic        rx_byte_vld;
   logic        rx_frame_start;
   logic        rx_in_frame;
   logic        rx_lof;
   logic        rx_ovf_err;

   modport master (
      output gtx_rx_data, gtx_rx_vld,
      input  rx_byte, rx_byte_vld, rx_frame_start, rx_in_frame, rx_lof, rx_ovf_err
   );

   modport slave (
      input  gtx_rx_data, gtx_rx_vld,
      output rx_byte, rx_byte_vld, rx_frame_start, rx_in_frame, rx_lof, rx_ovf_err
   );

endinterface
`default_nettype wire

// File: rtl/sdh_rx_frame_aligner_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : sdh_word_unpacker
// Brief    : 2-deep word buffer with sticky overflow, serialised MSB lane first.
// Revision : 1.0 - initial release
// ============================================================================
module sdh_word_unpacker (
   input  wire        clk,
   input  wire        rst_n,
   input  wire [31:0] i_data,
   input  wire        i_vld,
   output logic [7:0] o_byte,
   output logic       o_strb,
   output logic       o_ovf_err
);

   logic [31:0] r_mem [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   logic [31:0] r_word;
   logic [1:0]  r_lane;
   logic        r_active;
   logic        r_ovf;
   logic        w_pop;
   logic        w_push;

   // Next word is fetched while lane 0 is on the wire so strobes run gap-free.
   assign w_pop  = (!r_active || (r_lane == 2'd0)) && (r_count != 2'd0);
   assign w_push = i_vld && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_word   <= '0;
         r_lane   <= 2'd0;
         r_active <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_vld && !w_push) begin
            r_ovf <= 1'b1;
         end
         if (w_pop) begin
            r_word   <= r_mem[r_rd_ptr];
            r_rd_ptr <= ~r_rd_ptr;
            r_lane   <= 2'd3;
            r_active <= 1'b1;
         end else if (r_active) begin
            r_lane <= r_lane - 2'd1;
            if (r_lane == 2'd0) begin
               r_active <= 1'b0;
            end
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign o_byte    = r_word[{r_lane, 3'b000} +: 8];
   assign o_strb    = r_active;
   assign o_ovf_err = r_ovf;

endmodule
`default_nettype wire

// File: rtl/sdh_rx_frame_aligner.sv
`default_nettype none
// ============================================================================
// Module   : sdh_rx_frame_aligner
// Brief    : STM-1 A1/A2 frame hunter with confirm/flywheel, 32-bit GTX input.
// Revision : 1.0 - initial release
// ============================================================================
module sdh_rx_frame_aligner
   import sdh_rx_pkg::*;
#(
   parameter int         FRAME_BYTES = c_frame_bytes,
   parameter int         CONFIRM_CNT = 2,
   parameter int         LOSS_CNT    = 4,
   parameter logic [7:0] A1_BYTE     = c_a1_byte,
   parameter logic [7:0] A2_BYTE     = c_a2_byte
) (
   input  wire                   sdh_clk,
   input  wire                   rst_n,
   sdh_rx_frame_aligner_if.slave bus
);

   localparam int c_cnt_w  = $clog2(FRAME_BYTES);
   localparam int c_good_w = $clog2(CONFIRM_CNT + 1);
   localparam int c_bad_w  = $clog2(LOSS_CNT + 1);

   localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(FRAME_BYTES - 1);
   localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
   localparam logic [c_good_w-1:0] c_good_one  = c_good_w'(1);
   localparam logic [c_good_w-1:0] c_good_done = c_good_w'(CONFIRM_CNT);
   localparam logic [c_bad_w-1:0]  c_bad_one   = c_bad_w'(1);
   localparam logic [c_bad_w-1:0]  c_bad_lost  = c_bad_w'(LOSS_CNT);

   logic [7:0]          r_dl [6];
   logic [2:0]          r_fill;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [c_good_w-1:0] r_good;
   logic [c_bad_w-1:0]  r_bad;
   state_t              r_state;
   logic [7:0]          r_byte;
   logic                r_byte_vld;
   logic                r_frame_start;
   logic                r_in_frame;
   logic                r_lof;

   logic [7:0]          w_byte;
   logic                w_strb;
   logic                w_ovf_err;
   logic                w_out;
   logic                w_match;
   logic                w_expect;
   logic [c_good_w-1:0] w_good_inc;
   logic [c_bad_w-1:0]  w_bad_inc;

   sdh_word_unpacker u_unpacker (
      .clk       (sdh_clk),
      .rst_n     (rst_n),
      .i_data    (bus.gtx_rx_data),
      .i_vld     (bus.gtx_rx_vld),
      .o_byte    (w_byte),
      .o_strb    (w_strb),
      .o_ovf_err (w_ovf_err)
   );

   // r_dl[5] is the oldest byte: the one leaving the line on this strobe.
   assign w_out      = w_strb && (r_fill == 3'd6);
   assign w_match    = (r_dl[5] == A1_BYTE) && (r_dl[4] == A1_BYTE) && (r_dl[3] == A1_BYTE) &&
                       (r_dl[2] == A2_BYTE) && (r_dl[1] == A2_BYTE) && (r_dl[0] == A2_BYTE);
   assign w_expect   = (r_cnt == '0);
   assign w_good_inc = r_good + c_good_one;
   assign w_bad_inc  = r_bad + c_bad_one;

   always_ff @(posedge sdh_clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) begin
            r_dl[i] <= '0;
         end
         r_fill        <= 3'd0;
         r_cnt         <= '0;
         r_good        <= '0;
         r_bad         <= '0;
         r_state       <= HUNT;
         r_byte        <= '0;
         r_byte_vld    <= 1'b0;
         r_frame_start <= 1'b0;
         r_in_frame    <= 1'b0;
         r_lof         <= 1'b1;
      end else begin
         r_byte_vld    <= w_out;
         r_frame_start <= w_out && (r_state == SYNC) && w_expect;
         if (w_strb) begin
            r_dl[0] <= w_byte;
            for (int i = 1; i < 6; i++) begin
               r_dl[i] <= r_dl[i-1];
            end
            if (r_fill != 3'd6) begin
               r_fill <= r_fill + 3'd1;
            end
         end
         if (w_out) begin
            r_byte <= r_dl[5];
            r_cnt  <= (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_one;
            unique case (r_state)
               HUNT: begin
                  // Matched byte is outputting now with count 0.
                  if (w_match) begin
                     r_cnt   <= c_cnt_one;
                     r_good  <= c_good_one;
                     r_state <= PRESYNC;
                  end
               end
               PRESYNC: begin
                  if (w_expect) begin
                     if (w_match) begin
                        r_good <= w_good_inc;
                        if (w_good_inc == c_good_done) begin
                           r_state    <= SYNC;
                           r_bad      <= '0;
                           r_in_frame <= 1'b1;
                           r_lof      <= 1'b0;
                        end
                     end else begin
                        r_state <= HUNT;
                     end
                  end
               end
               SYNC: begin
                  if (w_expect) begin
                     if (w_match) begin
                        r_bad <= '0;
                     end else begin
                        r_bad <= w_bad_inc;
                        if (w_bad_inc == c_bad_lost) begin
                           r_state    <= HUNT;
                           r_in_frame <= 1'b0;
                           r_lof      <= 1'b1;
                        end
                     end
                  end
               end
               default: r_state <= HUNT;
            endcase
         end
      end
   end

   assign bus.rx_byte        = r_byte;
   assign bus.rx_byte_vld    = r_byte_vld;
   assign bus.rx_frame_start = r_frame_start;
   assign bus.rx_in_frame    = r_in_frame;
   assign bus.rx_lof         = r_lof;
   assign bus.rx_ovf_err     = w_ovf_err;

endmodule
`default_nettype wire
